uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled start/data/parity/stop framing with a registered FIFO write port.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote over counter 6/7/8 samples.
module uart_rx_core (
    input  logic       clk26m,
    input  logic       rst26m,
    input  logic       rx_in,
    input  logic       rx_bps_clk,
    input  logic       check_en,
    input  logic       parity,
    input  logic       stop_bit,
    input  logic       rx_fifo_wfull,
    output logic       rx_bps_en,
    output logic       rx_fifo_wr_en,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_sync_p0;
    logic       r_sync_p1;
    logic       r_sync_p2;
    logic [3:0] r_tick_cnt;
    logic [3:0] w_tick_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_chk_en;
    logic       r_par_sel;
    logic       r_stop_en;
    logic       r_par_err;
    logic       w_par_err_nxt;
    logic       w_fall;
    logic       w_decide;
    logic       w_bit;
    logic       w_boundary;
    logic       w_exp_par;
    logic       w_latch;
    logic       w_end;
    logic       w_perr;
    logic       w_ferr;

    assign w_fall     = r_sync_p2 & ~r_sync_p1;
    assign w_boundary = rx_bps_clk && (r_tick_cnt == 4'd15);
    assign w_exp_par  = r_par_sel ? (^r_shift) : ~(^r_shift);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_smp6;
    logic r_smp7;

    always_ff @(posedge clk26m) begin
        if (rx_bps_clk && (r_tick_cnt == 4'd6)) r_smp6 <= r_sync_p1;
        if (rx_bps_clk && (r_tick_cnt == 4'd7)) r_smp7 <= r_sync_p1;
    end

    assign w_decide = rx_bps_clk && (r_tick_cnt == 4'd8);
    assign w_bit    = (r_smp6 & r_smp7) | (r_smp6 & r_sync_p1) | (r_smp7 & r_sync_p1);
`else
    assign w_decide = rx_bps_clk && (r_tick_cnt == 4'd7);
    assign w_bit    = r_sync_p1;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick_cnt;
        w_bit_nxt     = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_err_nxt = r_par_err;
        w_latch       = 1'b0;
        w_end         = 1'b0;
        w_perr        = r_par_err;
        w_ferr        = 1'b0;
        if ((r_state != S_IDLE) && rx_bps_clk) w_tick_nxt = r_tick_cnt + 4'd1;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = S_START;
                    w_tick_nxt    = 4'd0;
                    w_bit_nxt     = 3'd0;
                    w_par_err_nxt = 1'b0;
                    w_latch       = 1'b1;
                end
            end
            S_START: begin
                if (w_decide && w_bit) w_state_nxt = S_IDLE;
                else if (w_boundary)   w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_decide) w_shift_nxt[r_bit_cnt] = w_bit;
                if (w_boundary) begin
                    w_bit_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = r_chk_en ? S_CHECK : S_STOP;
                end
            end
            S_CHECK: begin
                // Without a stop bit the frame closes on the parity decision itself.
                if (w_decide) begin
                    w_perr        = (w_bit != w_exp_par);
                    w_par_err_nxt = w_perr;
                    if (!r_stop_en) begin
                        w_end       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_boundary) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_decide) begin
                    w_ferr      = ~w_bit;
                    w_end       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            r_state    <= S_IDLE;
            r_sync_p0  <= 1'b1;
            r_sync_p1  <= 1'b1;
            r_sync_p2  <= 1'b1;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_chk_en   <= 1'b0;
            r_par_sel  <= 1'b0;
            r_stop_en  <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_p0  <= rx_in;
            r_sync_p1  <= r_sync_p0;
            r_sync_p2  <= r_sync_p1;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_par_err  <= w_par_err_nxt;
            if (w_latch) begin
                r_chk_en  <= check_en;
                r_par_sel <= parity;
                r_stop_en <= stop_bit;
            end
        end
    end

    always_ff @(posedge clk26m) begin
        r_shift <= w_shift_nxt;
    end

    // Outputs are registered from next-state terms so they line up with the state change.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            rx_bps_en     <= 1'b0;
            rx_busy       <= 1'b0;
            rx_fifo_wr_en <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_data       <= 8'h00;
        end else begin
            rx_bps_en     <= (w_state_nxt != S_IDLE);
            rx_busy       <= (w_state_nxt != S_IDLE);
            rx_fifo_wr_en <= w_end & ~rx_fifo_wfull;
            rx_overrun    <= w_end & rx_fifo_wfull;
            rx_parity_err <= w_end & w_perr;
            rx_frame_err  <= w_end & w_ferr;
            if (w_end && !rx_fifo_wfull) rx_data <= w_shift_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core; bit period is 64 clocks (tick every 4 clocks, 16 ticks per bit).
module tb_uart_rx_core;

    logic       clk26m = 1'b0;
    logic       rst26m;
    logic       rx_in;
    logic       rx_bps_clk;
    logic       check_en;
    logic       parity;
    logic       stop_bit;
    logic       rx_fifo_wfull;
    logic       rx_bps_en;
    logic       rx_fifo_wr_en;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;

    int n_wr = 0;
    int n_perr = 0;
    int n_perr_wr = 0;
    int n_ferr = 0;
    int n_ferr_wr = 0;
    int n_ovr = 0;
    logic [7:0] last_data = 8'h00;

    int b_wr, b_perr, b_perr_wr, b_ferr, b_ferr_wr, b_ovr;

    logic [1:0] r_tcnt;

    always #5 clk26m = ~clk26m;

    always @(posedge clk26m) r_tcnt <= rx_bps_en ? r_tcnt + 2'd1 : 2'd0;
    assign rx_bps_clk = rx_bps_en && (r_tcnt == 2'd3);

    uart_rx_core dut (
        .clk26m        (clk26m),
        .rst26m        (rst26m),
        .rx_in         (rx_in),
        .rx_bps_clk    (rx_bps_clk),
        .check_en      (check_en),
        .parity        (parity),
        .stop_bit      (stop_bit),
        .rx_fifo_wfull (rx_fifo_wfull),
        .rx_bps_en     (rx_bps_en),
        .rx_fifo_wr_en (rx_fifo_wr_en),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    always @(negedge clk26m) begin
        if (rx_fifo_wr_en) begin
            n_wr++;
            last_data = rx_data;
        end
        if (rx_parity_err) begin
            n_perr++;
            if (rx_fifo_wr_en) n_perr_wr++;
        end
        if (rx_frame_err) begin
            n_ferr++;
            if (rx_fifo_wr_en) n_ferr_wr++;
        end
        if (rx_overrun) n_ovr++;
    end

    task automatic snap();
        b_wr = n_wr; b_perr = n_perr; b_perr_wr = n_perr_wr;
        b_ferr = n_ferr; b_ferr_wr = n_ferr_wr; b_ovr = n_ovr;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop_val, input int glitch_idx);
        logic [10:0] bits;
        int n;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (has_par) begin
            bits[9] = par_bit; bits[10] = stop_val; n = 11;
        end else begin
            bits[9] = stop_val; n = 10;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk26m); #1 rx_in = bits[i];
            if (i == glitch_idx) begin
                repeat (31) @(posedge clk26m); #1 rx_in = ~bits[i];
                repeat (4) @(posedge clk26m);  #1 rx_in = bits[i];
                repeat (28) @(posedge clk26m);
            end else begin
                repeat (63) @(posedge clk26m);
            end
        end
        @(posedge clk26m); #1 rx_in = 1'b1;
        repeat (40) @(posedge clk26m);
    endtask

    task automatic test_reset();
        rst26m = 1'b1; rx_in = 1'b1; check_en = 1'b0; parity = 1'b0;
        stop_bit = 1'b1; rx_fifo_wfull = 1'b0;
        repeat (4) @(posedge clk26m);
        @(negedge clk26m);
        checks++; if (rx_bps_en !== 1'b0) begin errors++; $display("FAIL reset_bps_en: got %b expected 0", rx_bps_en); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        checks++; if (rx_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", rx_fifo_wr_en); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin errors++;
            $display("FAIL reset_status: got %b expected 000", {rx_parity_err, rx_frame_err, rx_overrun}); end
        @(posedge clk26m); #1 rst26m = 1'b0;
        repeat (5) @(posedge clk26m);
    endtask

    task automatic test_basic();
        check_en = 1'b0;
        snap();
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
            begin
                repeat (300) @(negedge clk26m);
                checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", rx_busy); end
            end
        join
        checks++; if (n_wr - b_wr !== 1) begin errors++; $display("FAIL basic_wr_count: got %0d expected 1", n_wr - b_wr); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", last_data); end
        checks++; if ((n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr) !== 0) begin errors++;
            $display("FAIL basic_status: got %0d error pulses expected 0", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr)); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", rx_busy); end
    endtask

    task automatic test_parity();
        logic [7:0] v_data [4] = '{8'h3C, 8'h3C, 8'h3C, 8'h07};
        logic       v_sel  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       v_pbit [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int         v_err  [4] = '{1, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            check_en = 1'b1; parity = v_sel[k]; stop_bit = 1'b1;
            snap();
            send_frame(v_data[k], 1'b1, v_pbit[k], 1'b1, -1);
            checks++; if (n_wr - b_wr !== 1) begin errors++; $display("FAIL parity_wr[%0d]: got %0d expected 1", k, n_wr - b_wr); end
            checks++; if (last_data !== v_data[k]) begin errors++; $display("FAIL parity_data[%0d]: got %h expected %h", k, last_data, v_data[k]); end
            checks++; if (n_perr_wr - b_perr_wr !== v_err[k]) begin errors++;
                $display("FAIL parity_err[%0d]: got %0d expected %0d", k, n_perr_wr - b_perr_wr, v_err[k]); end
            checks++; if (n_ferr - b_ferr !== 0) begin errors++; $display("FAIL parity_ferr[%0d]: got %0d expected 0", k, n_ferr - b_ferr); end
        end
        check_en = 1'b0;
    endtask

    task automatic test_frame_err();
        check_en = 1'b0;
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        checks++; if (n_ferr_wr - b_ferr_wr !== 1) begin errors++; $display("FAIL frame_err: got %0d expected 1", n_ferr_wr - b_ferr_wr); end
        checks++; if (n_wr - b_wr !== 1) begin errors++; $display("FAIL frame_wr: got %0d expected 1", n_wr - b_wr); end
        checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL frame_data: got %h expected 55", last_data); end
        checks++; if (n_perr - b_perr !== 0) begin errors++; $display("FAIL frame_perr: got %0d expected 0", n_perr - b_perr); end
    endtask

    task automatic test_false_start();
        snap();
        @(posedge clk26m); #1 rx_in = 1'b0;
        repeat (10) @(posedge clk26m);
        @(negedge clk26m);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_mid: got %b expected 1", rx_busy); end
        repeat (6) @(posedge clk26m); #1 rx_in = 1'b1;
        repeat (80) @(posedge clk26m);
        @(negedge clk26m);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_idle: got %b expected 0", rx_busy); end
        checks++; if (n_wr - b_wr !== 0) begin errors++; $display("FAIL false_start_wr: got %0d expected 0", n_wr - b_wr); end
        checks++; if ((n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr) !== 0) begin errors++;
            $display("FAIL false_start_status: got %0d expected 0", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr)); end
    endtask

    task automatic test_overrun();
        check_en = 1'b0; rx_fifo_wfull = 1'b1;
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1);
        checks++; if (n_wr - b_wr !== 0) begin errors++; $display("FAIL overrun_wr: got %0d expected 0", n_wr - b_wr); end
        checks++; if (n_ovr - b_ovr !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", n_ovr - b_ovr); end
        rx_fifo_wfull = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        check_en = 1'b0;
        snap();
        bits = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk26m); #1 rx_in = bits[i];
            if (i == 4) begin
                repeat (20) @(posedge clk26m); #1 rst26m = 1'b1;
                repeat (2) @(posedge clk26m);
                @(negedge clk26m);
                checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", rx_busy); end
                repeat (41) @(posedge clk26m);
            end else if (i == 8) begin
                repeat (10) @(posedge clk26m); #1 rst26m = 1'b0;
                repeat (53) @(posedge clk26m);
            end else begin
                repeat (63) @(posedge clk26m);
            end
        end
        repeat (40) @(posedge clk26m);
        send_frame(8'h18, 1'b0, 1'b0, 1'b1, -1);
        checks++; if (n_wr - b_wr !== 1) begin errors++; $display("FAIL midreset_wr: got %0d expected 1", n_wr - b_wr); end
        checks++; if (last_data !== 8'h18) begin errors++; $display("FAIL midreset_data: got %h expected 18", last_data); end
        checks++; if (n_ferr - b_ferr !== 0) begin errors++; $display("FAIL midreset_ferr: got %0d expected 0", n_ferr - b_ferr); end
    endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
    task automatic test_glitch();
        check_en = 1'b0;
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 3);
        checks++; if (n_wr - b_wr !== 1) begin errors++; $display("FAIL glitch_wr: got %0d expected 1", n_wr - b_wr); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h expected a5", last_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_false_start();
        test_overrun();
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_VOTE_EN
        test_glitch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
